// File: rtl/led_matrix_pkg.sv
// Shared constants and types for the tricolour status LED colour-wheel fader.
// Contents: phase encodings (0..5 round the wheel), duty type, PWM and wheel limits.
// Imported by led_matrix_top and led_pwm_channel.
package led_matrix_pkg;

   localparam int DUTY_W = 8;
   typedef logic [DUTY_W-1:0] duty_t;
   typedef logic [2:0]        phase_t;

   // Wheel phases, named after which channels are full, rising (UP) or falling (DN)
   localparam phase_t PH_R_GUP = 3'd0;   // R full,  G rising
   localparam phase_t PH_RDN_G = 3'd1;   // R falling, G full
   localparam phase_t PH_G_BUP = 3'd2;   // G full,  B rising
   localparam phase_t PH_GDN_B = 3'd3;   // G falling, B full
   localparam phase_t PH_RUP_B = 3'd4;   // R rising, B full
   localparam phase_t PH_R_BDN = 3'd5;   // R full,  B falling

   localparam duty_t  PWM_MAX    = 8'd255;
   localparam phase_t PHASE_LAST = PH_R_BDN;

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM colour channel: shadow duty register, compare, registered active-low pin.
// Ports: clk/rst_n; pwm_cnt shared counter; load = period-boundary strobe;
//        target = duty to adopt at the boundary; led_n = active-low LED drive.
module led_pwm_channel
   import led_matrix_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  duty_t pwm_cnt,
   input  logic  load,
   input  duty_t target,
   output logic  led_n
);

   duty_t shadow;

   // Duty only changes on the last count of a period, so every 256-cycle
   // window is driven by a single, whole duty value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= '0;
         led_n  <= 1'b1;
      end else begin
         if (load) begin
            shadow <= target;
         end
         led_n <= !(pwm_cnt < shadow);
      end
   end

endmodule

// File: rtl/led_matrix_top.sv
// Board status LED: fades an active-low RGB LED round a 6-phase colour wheel.
// Ports: OSC_CLK_IN single clock; RESET_ async active-low reset;
//        LED_R_/LED_G_/LED_B_ active-low LED pins (1 = off), registered.
module led_matrix_top
   import led_matrix_pkg::*;
#(
   parameter int PRESCALE = 16,   // oscillator cycles per wheel step, 1..65535
   parameter int PWM_BITS = 8     // PWM width; this revision supports 8 only
)
(
   input  logic OSC_CLK_IN,
   input  logic RESET_,
   output logic LED_R_,
   output logic LED_G_,
   output logic LED_B_
);

   logic [15:0]         pre_cnt;
   logic                tick;
   logic [PWM_BITS-1:0] step;
   phase_t              phase;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                load;
   duty_t               tgt_r;
   duty_t               tgt_g;
   duty_t               tgt_b;
   duty_t               up;
   duty_t               down;

   // Prescaler: counts 0..PRESCALE-1; with PRESCALE = 1 tick is constant high.
   assign tick = (pre_cnt == 16'(PRESCALE - 1));

   always_ff @(posedge OSC_CLK_IN or negedge RESET_) begin
      if (!RESET_) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 16'd1;
      end
   end

   // Wheel sequencer: 256 steps per phase, phase wraps after PHASE_LAST.
   always_ff @(posedge OSC_CLK_IN or negedge RESET_) begin
      if (!RESET_) begin
         step  <= '0;
         phase <= PH_R_GUP;
      end else if (tick) begin
         if (step == PWM_MAX) begin
            step  <= '0;
            phase <= (phase == PHASE_LAST) ? PH_R_GUP : phase + 3'd1;
         end else begin
            step <= step + 8'd1;
         end
      end
   end

   // Free-running PWM counter; its final count is the shadow-load strobe.
   always_ff @(posedge OSC_CLK_IN or negedge RESET_) begin
      if (!RESET_) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
      end
   end

   assign load = (pwm_cnt == PWM_MAX);
   assign up   = step;
   assign down = PWM_MAX - step;

   // Target duty per phase. On a cycle where tick and load coincide the
   // shadows latch these pre-tick values; the new step shows next period.
   always_comb begin
      tgt_r = '0;
      tgt_g = '0;
      tgt_b = '0;
      case (phase)
         PH_R_GUP: begin tgt_r = PWM_MAX; tgt_g = up;      end
         PH_RDN_G: begin tgt_r = down;    tgt_g = PWM_MAX; end
         PH_G_BUP: begin tgt_g = PWM_MAX; tgt_b = up;      end
         PH_GDN_B: begin tgt_g = down;    tgt_b = PWM_MAX; end
         PH_RUP_B: begin tgt_r = up;      tgt_b = PWM_MAX; end
         PH_R_BDN: begin tgt_r = PWM_MAX; tgt_b = down;    end
         default:  begin tgt_r = '0;      tgt_g = '0;      end
      endcase
   end

   led_pwm_channel u_red (
      .clk     (OSC_CLK_IN),
      .rst_n   (RESET_),
      .pwm_cnt (pwm_cnt),
      .load    (load),
      .target  (tgt_r),
      .led_n   (LED_R_)
   );

   led_pwm_channel u_green (
      .clk     (OSC_CLK_IN),
      .rst_n   (RESET_),
      .pwm_cnt (pwm_cnt),
      .load    (load),
      .target  (tgt_g),
      .led_n   (LED_G_)
   );

   led_pwm_channel u_blue (
      .clk     (OSC_CLK_IN),
      .rst_n   (RESET_),
      .pwm_cnt (pwm_cnt),
      .load    (load),
      .target  (tgt_b),
      .led_n   (LED_B_)
   );

endmodule

// File: tb/tb_led_matrix_top.sv
// Bench for led_matrix_top: three instances (PRESCALE 16, 1, 256) share clock
// and reset; LED pins are checked cycle by cycle against 256-cycle PWM windows.
module tb_led_matrix_top;

   logic osc_clk = 1'b0;
   logic reset_n = 1'b0;
   logic [2:0] led [3];   // [dut][0=R,1=G,2=B]

   int compared   = 0;
   int mismatched = 0;
   int pres [3]   = '{16, 1, 256};
   int rec_lows [3][3][40];
   int x_seen     = 0;
   bit toggled [3];        // PRESCALE=16 instance, per channel
   logic prev16 [3];
   int first_b_low = -1;

   always #4 osc_clk = ~osc_clk;

   led_matrix_top #(.PRESCALE(16)) dut16 (
      .OSC_CLK_IN (osc_clk), .RESET_ (reset_n),
      .LED_R_ (led[0][0]), .LED_G_ (led[0][1]), .LED_B_ (led[0][2]));
   led_matrix_top #(.PRESCALE(1)) dut1 (
      .OSC_CLK_IN (osc_clk), .RESET_ (reset_n),
      .LED_R_ (led[1][0]), .LED_G_ (led[1][1]), .LED_B_ (led[1][2]));
   led_matrix_top #(.PRESCALE(256)) dut256 (
      .OSC_CLK_IN (osc_clk), .RESET_ (reset_n),
      .LED_R_ (led[2][0]), .LED_G_ (led[2][1]), .LED_B_ (led[2][2]));

   task automatic chk(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Colour-wheel table: duty of channel ch after s wheel steps.
   function automatic int wheel_duty(input int s, input int ch);
      int st, ph;
      st = s % 256;
      ph = (s / 256) % 6;
      case (ph)
         0: return (ch == 0) ? 255 : (ch == 1) ? st : 0;
         1: return (ch == 0) ? 255 - st : (ch == 1) ? 255 : 0;
         2: return (ch == 0) ? 0 : (ch == 1) ? 255 : st;
         3: return (ch == 0) ? 0 : (ch == 1) ? 255 - st : 255;
         4: return (ch == 0) ? st : (ch == 1) ? 0 : 255;
         default: return (ch == 0) ? 255 : (ch == 1) ? 0 : 255 - st;
      endcase
   endfunction

   // Window w = LED values after edges 256w+1..256w+256 from reset release.
   // Its duty was latched at edge 256w from the wheel state after
   // floor((256w-1)/P) ticks; window 0 runs on the reset shadow of 0.
   function automatic int window_duty(input int d, input int w, input int ch);
      if (w == 0) return 0;
      return wheel_duty((256 * w - 1) / pres[d], ch);
   endfunction

   task automatic run_window(input int w);
      int lows [3][3];
      int bad  [3][3];
      int duty [3][3];
      for (int d = 0; d < 3; d++)
         for (int c = 0; c < 3; c++) begin
            lows[d][c] = 0;
            bad[d][c]  = 0;
            duty[d][c] = window_duty(d, w, c);
         end
      for (int i = 0; i < 256; i++) begin
         @(posedge osc_clk);
         @(negedge osc_clk);
         for (int d = 0; d < 3; d++)
            for (int c = 0; c < 3; c++) begin
               if ($isunknown(led[d][c])) x_seen++;
               if (led[d][c] === 1'b0) lows[d][c]++;
               if (led[d][c] !== ((i < duty[d][c]) ? 1'b0 : 1'b1)) bad[d][c]++;
            end
         for (int c = 0; c < 3; c++) begin
            if (led[0][c] !== prev16[c]) toggled[c] = 1'b1;
            prev16[c] = led[0][c];
         end
         if (led[0][2] === 1'b0 && first_b_low < 0) first_b_low = w;
      end
      for (int d = 0; d < 3; d++)
         for (int c = 0; c < 3; c++) begin
            chk($sformatf("lows_p%0d_ch%0d_w%0d", pres[d], c, w), lows[d][c], duty[d][c]);
            chk($sformatf("shape_p%0d_ch%0d_w%0d", pres[d], c, w), bad[d][c], 0);
            if (w < 40) rec_lows[d][c][w] = lows[d][c];
         end
   endtask

   task automatic chk_all_off(input string tag);
      chk({tag, "_p16"},  int'(led[0]), 7);
      chk({tag, "_p1"},   int'(led[1]), 7);
      chk({tag, "_p256"}, int'(led[2]), 7);
   endtask

   initial begin
      // Reset held for 5 cycles: all pins off
      reset_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge osc_clk);
         chk_all_off("reset_hold");
      end
      for (int c = 0; c < 3; c++) prev16[c] = 1'b1;

      // Release between edges; next posedge is edge 1
      reset_n = 1'b1;
      for (int w = 0; w < 39; w++) run_window(w);

      // Hand-computed window duties
      chk("p16_w1_R",  rec_lows[0][0][1], 255);
      chk("p16_w1_G",  rec_lows[0][1][1], 15);
      chk("p16_w1_B",  rec_lows[0][2][1], 0);
      chk("p16_w2_G",  rec_lows[0][1][2], 31);
      chk("p16_w33_B", rec_lows[0][2][33], 15);
      chk("p1_w2_R",   rec_lows[1][0][2], 0);
      chk("p1_w2_G",   rec_lows[1][1][2], 255);
      chk("p1_w2_B",   rec_lows[1][2][2], 0);
      chk("p1_w6_G",   rec_lows[1][1][6], 0);
      chk("p1_w7_R",   rec_lows[1][0][7], 255);
      chk("p1_w7_G",   rec_lows[1][1][7], 255);
      chk("p256_w1_G", rec_lows[2][1][1], 0);
      chk("p256_w2_G", rec_lows[2][1][2], 1);
      chk("p256_w3_G", rec_lows[2][1][3], 2);
      chk("p256_w3_R", rec_lows[2][0][3], 255);

      // Long run
      chk("no_x",        x_seen, 0);
      chk("p16_R_tog",   int'(toggled[0]), 1);
      chk("p16_G_tog",   int'(toggled[1]), 1);
      chk("p16_B_tog",   int'(toggled[2]), 1);
      chk("p16_B_first", first_b_low, 33);

      // Mid-run asynchronous reset: G of PRESCALE=16 is lit at window 39 index 0
      @(posedge osc_clk);
      #3;
      chk("pre_reset_G16", int'(led[0][1]), 0);
      reset_n = 1'b0;
      #1;
      chk_all_off("async_reset");
      for (int i = 0; i < 3; i++) begin
         @(negedge osc_clk);
         chk_all_off("reset_held");
      end

      // Restart from phase 0, step 0
      for (int c = 0; c < 3; c++) prev16[c] = 1'b1;
      reset_n = 1'b1;
      run_window(0);
      run_window(1);
      chk("restart_p16_w1_G", rec_lows[0][1][1], 15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
